i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//   Stereo I2S master transmitter driving the codec pins i2s_mclk/i2s_sclk/i2s_lrclk/i2s_sdata.
//   Upstream audio logic pushes left/right sample pairs over valid/ready into an internal FIFO.
//   The block serialises one pair per frame in Philips I2S format.
//   At ~98.3 MHz clk with defaults: MCLK = clk/4, SCLK = clk/32 (64 fs), LRCLK = clk/2048 (48 kHz).
// PARAMETERS
//   SAMPLE_W    16  sample width in bits per channel, 1..31
//   SCLK_HALF   16  SCLK half-period in clk cycles, >=2
//   MCLK_HALF    2  MCLK half-period in clk cycles, >=1
//   FIFO_DEPTH   4  sample-pair FIFO depth, power of 2, >=2
// PORTS
//   clk         in   1                     system clock
//   arst_n      in   1                     asynchronous active-low reset
//   enable      in   1                     1 = run SCLK/LRCLK and transmit frames
//   s_valid     in   1                     sample pair valid
//   s_ready     out  1                     FIFO not full
//   s_left      in   SAMPLE_W              left sample, two's complement
//   s_right     in   SAMPLE_W              right sample, two's complement
//   fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored
//   underrun    out  1                     1-cycle pulse: frame started with FIFO empty
//   i2s_mclk    out  1                     codec master clock
//   i2s_sclk    out  1                     bit clock
//   i2s_lrclk   out  1                     word select, 0 = left, 1 = right
//   i2s_sdata   out  1                     serial data
// BEHAVIOUR
//   Reset state (arst_n=0, asynchronous): all flops clear.
//     - all outputs 0 except s_ready=1; fifo_level=0; FIFO empty.
//   Output registration: all pin outputs come from flops. s_ready = !full, decoded from the level register.
//   FIFO:
//     - push when s_valid && s_ready; pop only at frame start.
//     - Push and pop in the same cycle: level unchanged.
//     - When full, s_ready=0, so no push occurs even if a pop happens that cycle.
//     - A pop makes s_ready=1 on the next cycle.
//   MCLK: toggles every MCLK_HALF cycles whenever out of reset; independent of enable.
//   enable=0:
//     - sclk_cnt=0, slot position p=0, shift regs cleared.
//     - i2s_sclk, i2s_lrclk, i2s_sdata forced 0 on the next clk edge.
//     - FIFO contents and level are retained; pushes are still accepted.
//   Bit timing while enabled:
//     - sclk_cnt counts 0..2*SCLK_HALF-1 and wraps.
//     - i2s_sclk=1 for sclk_cnt >= SCLK_HALF.
//     - Falling-edge event = the cycle sclk_cnt wraps to 0; p (0..63) advances by 1 mod 64 at each event.
//   Frame start:
//     - occurs at the first enabled cycle after enable=0, and at every falling-edge event where p wraps 63 -> 0.
//     - If the FIFO is non-empty, pop into shift regs L, R.
//     - If the FIFO is empty, load L=R=0 and pulse underrun for one cycle.
//   Serial format, updated on falling-edge events only, so the codec samples on SCLK rise:
//     - i2s_lrclk = p[5], changing one SCLK before the MSB.
//     - i2s_sdata = L[SAMPLE_W-p] for p in 1..SAMPLE_W.
//     - i2s_sdata = R[SAMPLE_W-(p-32)] for p in 33..32+SAMPLE_W.
//     - i2s_sdata = 0 at all other p (slot padding).
//   Frame length: 64*2*SCLK_HALF clk cycles (2048 with defaults); one pair consumed per frame.
//   enable dropping mid-frame: the frame is abandoned, its popped pair is discarded, and nothing is re-popped.
//     Re-enable restarts at p=0 with a new frame start.
//   Reset mid-operation: immediate clear of everything, including FIFO contents.
// TESTING (defaults)
//   1. arst_n=0 for 10 clk, then release.
//      -> all pins 0, s_ready=1, fifo_level=0, underrun=0.
//      -> i2s_mclk period is 4 clk while enable=0.
//   2. Push L=16'hA5F0, R=16'h0F0F, then enable=1.
//      -> Sample sdata at SCLK rises.
//      -> Slots 1..16 read A5F0 with lrclk=0; slots 33..48 read 0F0F with lrclk=1; all other bits 0.
//      -> Frame is 2048 clk long.
//   3. Push 4 pairs with enable=0.
//      -> fifo_level=4, s_ready=0, 5th pair stalls.
//      -> After enable, first frame start gives fifo_level=3 and s_ready=1 the next cycle; 5th pair accepted.
//   4. Enable with empty FIFO.
//      -> underrun pulses exactly 1 clk; frame is all zeros.
//      -> Pair pushed mid-frame appears in the next frame, with no further underrun.
//   5. Drop enable at p=20 with 2 pairs queued.
//      -> sclk/lrclk/sdata=0 next cycle, fifo_level stays 2.
//      -> Re-enable pops the next queued pair, not the abandoned one.
//   6. Assert arst_n=0 mid-frame with 3 pairs queued.
//      -> Outputs clear asynchronously, fifo_level=0.
//      -> After release and enable, the first frame underruns.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S master transmitter, Philips format.
// Upstream logic pushes left/right sample pairs over valid/ready into a small
// FIFO. One pair is serialised per 64-slot frame, MSB one SCLK after the LRCLK
// change. MCLK runs whenever the block is out of reset. SCLK, LRCLK and SDATA
// run only while enable is high. Every pin is driven straight from a flop.
module i2s_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SCLK_HALF  = 16,
  parameter int MCLK_HALF  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        enable,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [SAMPLE_W-1:0]         s_left,
  input  logic [SAMPLE_W-1:0]         s_right,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic                        i2s_mclk,
  output logic                        i2s_sclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(2 * SCLK_HALF);
  localparam int MCNT_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  localparam logic [SCNT_W-1:0] SCNT_LAST   = SCNT_W'(2 * SCLK_HALF - 1);
  localparam logic [SCNT_W-1:0] SCNT_HIGH   = SCNT_W'(SCLK_HALF);
  localparam logic [MCNT_W-1:0] MCNT_LAST   = MCNT_W'(MCLK_HALF - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(FIFO_DEPTH);
  localparam logic [5:0]        LEFT_FIRST  = 6'd1;
  localparam logic [5:0]        LEFT_LAST   = 6'(SAMPLE_W);
  localparam logic [5:0]        RIGHT_FIRST = 6'd33;
  localparam logic [5:0]        RIGHT_LAST  = 6'(32 + SAMPLE_W);
  localparam logic [5:0]        SLOT_LAST   = 6'd63;

  // MCLK divider
  logic [MCNT_W-1:0] mclk_cnt;

  // Sample-pair FIFO
  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // Frame engine
  logic                en_d;        // enable was high last cycle
  logic [SCNT_W-1:0]   sclk_cnt;
  logic [SCNT_W-1:0]   sclk_cnt_nxt;
  logic [5:0]          slot;        // slot position p within the frame
  logic [5:0]          slot_nxt;
  logic [SAMPLE_W-1:0] sh_l;
  logic [SAMPLE_W-1:0] sh_r;
  logic                sclk_evt;    // SCLK falling-edge event
  logic                frame_start;
  logic                in_left;
  logic                in_right;
  logic                sdata_nxt;

  assign fifo_empty  = (fifo_level == '0);
  assign s_ready     = (fifo_level != LVL_FULL);
  assign push        = s_valid && s_ready;
  assign sclk_evt    = enable && (sclk_cnt == SCNT_LAST);
  assign frame_start = enable && (!en_d || (sclk_evt && (slot == SLOT_LAST)));
  assign pop         = frame_start && !fifo_empty;

  // Free-running MCLK divider, independent of enable.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample pre-edge values regardless of block evaluation order.
    if (!arst_n) begin
      mclk_cnt <= '0;
      i2s_mclk <= 1'b0;
    end else if (mclk_cnt == MCNT_LAST) begin
      mclk_cnt <= '0;
      i2s_mclk <= ~i2s_mclk;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end

  // FIFO storage, pointers and level; pops happen only at frame start.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: the storage array is reset along with the pointers so a reset
      // leaves no stale sample pairs behind anywhere in the block.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem_l[wr_ptr] <= s_left;
        mem_r[wr_ptr] <= s_right;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
    end
  end

  // Next bit-clock count, next slot and the bit to present at the next event.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value held and no latch is inferred.
    sclk_cnt_nxt = sclk_cnt + 1'b1;
    if (sclk_evt) begin
      sclk_cnt_nxt = '0;
    end
    slot_nxt  = slot + 6'd1;
    in_left   = (slot_nxt >= LEFT_FIRST) && (slot_nxt <= LEFT_LAST);
    in_right  = (slot_nxt >= RIGHT_FIRST) && (slot_nxt <= RIGHT_LAST);
    sdata_nxt = 1'b0;
    if (in_left) begin
      sdata_nxt = sh_l[SAMPLE_W-1];
    end else if (in_right) begin
      sdata_nxt = sh_r[SAMPLE_W-1];
    end
  end

  // Bit clock, slot position, shift registers and serial pins.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      en_d      <= 1'b0;
      sclk_cnt  <= '0;
      slot      <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (!enable) begin
      // Abandon any frame in progress; a popped pair is discarded here.
      en_d      <= 1'b0;
      sclk_cnt  <= '0;
      slot      <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      en_d     <= 1'b1;
      sclk_cnt <= sclk_cnt_nxt;
      i2s_sclk <= (sclk_cnt_nxt >= SCNT_HIGH);
      if (sclk_evt) begin
        slot      <= slot_nxt;
        i2s_lrclk <= slot_nxt[5];
        i2s_sdata <= sdata_nxt;
      end
      if (frame_start) begin
        sh_l <= pop ? mem_l[rd_ptr] : '0;
        sh_r <= pop ? mem_r[rd_ptr] : '0;
      end else if (sclk_evt) begin
        if (in_left) begin
          sh_l <= sh_l << 1;
        end
        if (in_right) begin
          sh_r <= sh_r << 1;
        end
      end
    end
  end

  // One-cycle underrun flag when a frame starts with nothing to send.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && fifo_empty;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx at default parameters.
// A behavioural model (sample queue plus a frame-relative cycle index) predicts
// every output. A compare process checks the outputs on each falling clk edge.
// Directed scenarios add literal expectations on top of the model.
module tb_i2s_tx;

  localparam int SW      = 16;
  localparam int SH      = 16;
  localparam int MH      = 2;
  localparam int DEPTH   = 4;
  localparam int BIT_CYC = 2 * SH;
  localparam int FRAME   = 64 * BIT_CYC;

  logic                      clk     = 1'b0;
  logic                      arst_n  = 1'b0;
  logic                      enable  = 1'b0;
  logic                      s_valid = 1'b0;
  logic [SW-1:0]             s_left  = '0;
  logic [SW-1:0]             s_right = '0;
  logic                      s_ready;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      underrun;
  logic                      i2s_mclk;
  logic                      i2s_sclk;
  logic                      i2s_lrclk;
  logic                      i2s_sdata;

  int checks = 0;
  int errors = 0;

  i2s_tx #(
    .SAMPLE_W  (SW),
    .SCLK_HALF (SH),
    .MCLK_HALF (MH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .enable    (enable),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_left    (s_left),
    .s_right   (s_right),
    .fifo_level(fifo_level),
    .underrun  (underrun),
    .i2s_mclk  (i2s_mclk),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_act: a frame sequence is running; m_n: cycle index since enable rose.
  logic [SW-1:0] q_l[$];
  logic [SW-1:0] q_r[$];
  bit            m_act   = 1'b0;
  int            m_n     = 0;
  int            m_mcnt  = 0;
  bit            m_under = 1'b0;
  logic [SW-1:0] m_l     = '0;
  logic [SW-1:0] m_r     = '0;

  initial begin : model
    bit push_ok;
    bit fstart;
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        q_l.delete();
        q_r.delete();
        m_act   = 1'b0;
        m_n     = 0;
        m_mcnt  = 0;
        m_under = 1'b0;
        m_l     = '0;
        m_r     = '0;
      end else begin
        push_ok = s_valid && (q_l.size() < DEPTH);
        m_under = 1'b0;
        m_mcnt++;
        if (enable) begin
          if (!m_act) m_n = 0;
          fstart = !m_act || ((m_n % FRAME) == FRAME - 1);
          if (fstart) begin
            if (q_l.size() > 0) begin
              m_l = q_l.pop_front();
              m_r = q_r.pop_front();
            end else begin
              m_l     = '0;
              m_r     = '0;
              m_under = 1'b1;
            end
          end
          m_n++;
          m_act = 1'b1;
        end else begin
          m_act = 1'b0;
          m_n   = 0;
        end
        if (push_ok) begin
          q_l.push_back(s_left);
          q_r.push_back(s_right);
        end
      end
    end
  end

  // Compare every output against the model on each falling clk edge.
  always @(negedge clk) begin : compare
    int   ph;
    int   p;
    logic e_sclk;
    logic e_lr;
    logic e_sd;
    e_sclk = 1'b0;
    e_lr   = 1'b0;
    e_sd   = 1'b0;
    if (m_act) begin
      ph     = m_n % BIT_CYC;
      p      = (m_n / BIT_CYC) % 64;
      e_sclk = (ph >= SH);
      e_lr   = (p >= 32);
      if (p >= 1 && p <= SW) e_sd = m_l[SW-p];
      else if (p >= 33 && p <= 32 + SW) e_sd = m_r[SW-(p-32)];
    end
    check("mclk", i2s_mclk, (m_mcnt / MH) % 2);
    check("sclk", i2s_sclk, e_sclk);
    check("lrclk", i2s_lrclk, e_lr);
    check("sdata", i2s_sdata, e_sd);
    check("underrun", underrun, m_under);
    check("fifo_level", fifo_level, q_l.size());
    check("s_ready", s_ready, q_l.size() < DEPTH);
  end

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    while (!s_ready && guard < 3 * FRAME) begin
      tick(1);
      guard++;
    end
    check("push_ready", s_ready, 1);
    tick(1);
    s_valid = 1'b0;
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin : main
    int nr;
    int t_rise [2];
    logic prev;
    logic prev_lr;
    int k;
    int pad;
    int lr_bad;
    int nlr;
    int lr_t [2];
    logic [SW-1:0] left;
    logic [SW-1:0] right;
    int cnt;

    // 1. Reset state and MCLK period.
    tick(10);
    check("rst_sclk", i2s_sclk, 0);
    check("rst_lrclk", i2s_lrclk, 0);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_mclk", i2s_mclk, 0);
    check("rst_ready", s_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    arst_n = 1'b1;
    nr   = 0;
    prev = i2s_mclk;
    for (int i = 0; i < 40 && nr < 2; i++) begin
      tick(1);
      if (i2s_mclk && !prev) begin
        t_rise[nr] = i;
        nr++;
      end
      prev = i2s_mclk;
    end
    check("mclk_period", (nr == 2) ? t_rise[1] - t_rise[0] : -1, 4);

    // 2. One known pair; sample SDATA on SCLK rises.
    push_pair(16'hA5F0, 16'h0F0F);
    enable  = 1'b1;
    k       = 0;
    pad     = 0;
    lr_bad  = 0;
    nlr     = 0;
    left    = '0;
    right   = '0;
    prev    = i2s_sclk;
    prev_lr = i2s_lrclk;
    for (int i = 0; i < 3 * FRAME && nlr < 2; i++) begin
      tick(1);
      if (i2s_sclk && !prev) begin
        if (k < 64) begin
          if (k >= 1 && k <= 16) begin
            left = {left[SW-2:0], i2s_sdata};
            if (i2s_lrclk) lr_bad++;
          end else if (k >= 33 && k <= 48) begin
            right = {right[SW-2:0], i2s_sdata};
            if (!i2s_lrclk) lr_bad++;
          end else begin
            pad += int'(i2s_sdata);
            if (i2s_lrclk != (k >= 32)) lr_bad++;
          end
        end
        k++;
      end
      if (i2s_lrclk && !prev_lr) begin
        lr_t[nlr] = i;
        nlr++;
      end
      prev    = i2s_sclk;
      prev_lr = i2s_lrclk;
    end
    check("left_word", left, 16'hA5F0);
    check("right_word", right, 16'h0F0F);
    check("pad_bits", pad, 0);
    check("lrclk_slots", lr_bad, 0);
    check("frame_len", (nlr == 2) ? lr_t[1] - lr_t[0] : 0, 2048);
    enable = 1'b0;
    tick(2);

    // 3. Fill the FIFO while disabled, stall a 5th pair, release on enable.
    for (int i = 0; i < 4; i++) push_pair(SW'($urandom), SW'($urandom));
    check("full_level", fifo_level, 4);
    check("full_ready", s_ready, 0);
    s_valid = 1'b1;
    s_left  = SW'($urandom);
    s_right = SW'($urandom);
    tick(5);
    check("stall_level", fifo_level, 4);
    enable = 1'b1;
    tick(1);
    check("pop_level", fifo_level, 3);
    check("pop_ready", s_ready, 1);
    tick(1);
    s_valid = 1'b0;
    check("refill_level", fifo_level, 4);
    for (int i = 0; i < 6 * FRAME && fifo_level != 0; i++) tick(1);
    check("drain_level", fifo_level, 0);
    tick(FRAME);

    // 4. Enable with empty FIFO, then push mid-frame.
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      cnt += int'(underrun);
    end
    check("underrun_pulse", cnt, 1);
    tick(1000);
    push_pair(SW'($urandom), SW'($urandom));
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      tick(1);
      cnt += int'(underrun);
    end
    check("no_underrun", cnt, 0);
    check("popped_next", fifo_level, 0);
    tick(1200);

    // 5. Drop enable at p=20 with two pairs queued.
    enable = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) push_pair(SW'($urandom), SW'($urandom));
    enable = 1'b1;
    tick(1);
    check("enable_pop", fifo_level, 2);
    tick(20 * BIT_CYC);
    enable = 1'b0;
    tick(1);
    check("drop_sclk", i2s_sclk, 0);
    check("drop_lrclk", i2s_lrclk, 0);
    check("drop_sdata", i2s_sdata, 0);
    check("drop_level", fifo_level, 2);
    tick(3);
    enable = 1'b1;
    tick(1);
    check("reenable_level", fifo_level, 1);
    tick(1600);

    // 6. Asynchronous reset mid-frame with three pairs queued.
    push_pair(SW'($urandom), SW'($urandom));
    push_pair(SW'($urandom), SW'($urandom));
    check("pre_reset_level", fifo_level, 3);
    tick(200);
    arst_n = 1'b0;
    #1;
    check("arst_level", fifo_level, 0);
    check("arst_ready", s_ready, 1);
    check("arst_sclk", i2s_sclk, 0);
    check("arst_lrclk", i2s_lrclk, 0);
    check("arst_sdata", i2s_sdata, 0);
    tick(3);
    arst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      cnt += int'(underrun);
    end
    check("post_reset_underrun", cnt, 1);

    // 7. Random pushes and occasional enable toggles against the model.
    for (int i = 0; i < 12000; i++) begin
      s_valid = ($urandom_range(0, 999) < 2);
      s_left  = SW'($urandom);
      s_right = SW'($urandom);
      if ($urandom_range(0, 3999) == 0) enable = ~enable;
      tick(1);
    end
    s_valid = 1'b0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
